// File: rtl/instr_cache_controller.sv
// -----------------------------------------------------------------------------
// instr_cache_controller
//
// Miss-handling controller for a direct-mapped instruction cache. It looks up
// each fetch address through the cache array's combinational read port. A hit
// returns the instruction in the same cycle. A miss stalls fetch and refills
// the whole line from main memory over a req/ack handshake. It then spends one
// re-lookup cycle (RESUME) before returning to IDLE.
//
// Parameters
//   LINE_WORDS : words per refill line (power of two, 1..16)
//   TAG_W      : tag width; tag = a[31:32-TAG_W]
//
// Optional feature
//   ICACHE_STATS_EN : when defined, builds 32-bit hit/miss counters. When
//                     undefined, hit_count/miss_count are tied to zero.
//
// Ports
//   clk, reset_n            : clock, asynchronous active-low reset
//   req, pc                 : fetch request and byte address
//   instr, instr_valid      : fetched instruction (combinational on hit)
//   stall                   : fetch must hold pc/req
//   cache_a                 : cache array address (read and write)
//   cache_rv/rtag/rd        : cache array read valid, tag and data
//   cache_we/wtag/wvalid/wd : cache array write strobe and payload
//   mem_req/addr            : main-memory read request and word address
//   mem_ack/rdata           : main-memory acknowledge and data
//   hit_count, miss_count   : statistics counters
// -----------------------------------------------------------------------------
module instr_cache_controller #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TAG_W      = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic [31:0]      pc,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic             stall,
  output logic [31:0]      cache_a,
  input  logic             cache_rv,
  input  logic [TAG_W-1:0] cache_rtag,
  input  logic [31:0]      cache_rd,
  output logic             cache_we,
  output logic [TAG_W-1:0] cache_wtag,
  output logic             cache_wvalid,
  output logic [31:0]      cache_wd,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
);

  localparam int unsigned CNT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [31:0] LINE_MASK = 32'(4 * LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_RESUME = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      miss_addr_q, miss_addr_d;

  logic [31:0] refill_addr;
  logic        last_word;
  logic        hit;

  // Address of the word currently being refilled (wraps modulo 2^32).
  assign refill_addr = miss_addr_q + {30'(cnt_q), 2'b00};
  assign last_word   = (cnt_q == CNT_LAST);

  // The array is addressed by the refill word during REFILL and by pc otherwise.
  assign cache_a = (state_q == S_REFILL) ? refill_addr : pc;

  // Hit test against the tag of the address currently presented to the array.
  assign hit = cache_rv && (cache_rtag == cache_a[31:32-TAG_W]);

  // State, word counter and line base registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    miss_addr_d  = miss_addr_q;
    instr        = cache_rd;
    instr_valid  = 1'b0;
    stall        = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = refill_addr;
    cache_we     = 1'b0;
    cache_wtag   = miss_addr_q[31:32-TAG_W];
    cache_wvalid = 1'b0;
    cache_wd     = mem_rdata;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            instr_valid = 1'b1;
          end else begin
            stall       = 1'b1;
            miss_addr_d = pc & ~LINE_MASK;
            cnt_d       = '0;
            state_d     = S_REFILL;
          end
        end
      end

      S_REFILL: begin
        // Only the last word writes valid=1, so an aborted refill leaves the
        // line invalid.
        stall        = 1'b1;
        mem_req      = 1'b1;
        cache_we     = mem_ack;
        cache_wvalid = last_word;
        if (mem_ack) begin
          if (last_word) begin
            state_d = S_RESUME;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_RESUME: begin
        // Re-lookup cycle: the array now holds the refilled line.
        stall   = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef ICACHE_STATS_EN
  logic        hit_evt;
  logic        miss_evt;
  logic [31:0] hit_count_q, miss_count_q;

  assign hit_evt  = (state_q == S_IDLE) && req && hit;
  assign miss_evt = (state_q == S_IDLE) && req && !hit;

  // Free-running statistics counters; they wrap naturally at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit_evt) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (miss_evt) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_instr_cache_controller.sv
// -----------------------------------------------------------------------------
// tb_instr_cache_controller
//
// Self-checking bench. It models the cache array (per-line tag/valid, per-word
// data) and a main memory with random wait states. Expectations come from a
// line-level residency table: a line is resident after a refill completes.
// The instruction value is a fixed function of the word address.
// -----------------------------------------------------------------------------
module tb_instr_cache_controller;

  localparam int unsigned LW  = 4;
  localparam int unsigned TW  = 14;
  localparam int unsigned LB  = $clog2(LW);
  localparam int unsigned NL  = 2 ** (30 - TW - LB);
  localparam int unsigned NW  = 2 ** (30 - TW);
  localparam logic [31:0] LMASK = 32'(4 * LW - 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          stall;
  logic [31:0]   cache_a;
  logic          cache_rv;
  logic [TW-1:0] cache_rtag;
  logic [31:0]   cache_rd;
  logic          cache_we;
  logic [TW-1:0] cache_wtag;
  logic          cache_wvalid;
  logic [31:0]   cache_wd;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_hits   = 0;
  int exp_misses = 0;

  // Line-level residency: slot -> resident line base address.
  logic [31:0] resident [int];

  // Array model control.
  logic          clr_all = 1'b0;
  logic          pre_en  = 1'b0;
  logic [31:0]   pre_a   = '0;

  logic          lv [NL];
  logic [TW-1:0] lt [NL];
  logic [31:0]   dd [NW];

  always #5 clk = ~clk;

  instr_cache_controller #(.LINE_WORDS(LW), .TAG_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .pc(pc),
    .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .cache_a(cache_a), .cache_rv(cache_rv), .cache_rtag(cache_rtag),
    .cache_rd(cache_rd), .cache_we(cache_we), .cache_wtag(cache_wtag),
    .cache_wvalid(cache_wvalid), .cache_wd(cache_wd),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  function automatic logic [31:0] memval(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E3779B1) + 32'h01234567;
  endfunction

  function automatic int slot(input logic [31:0] a);
    return int'(a[31-TW:2+LB]);
  endfunction

  // Combinational array read port.
  always_comb begin
    cache_rv   = lv[cache_a[31-TW:2+LB]];
    cache_rtag = lt[cache_a[31-TW:2+LB]];
    cache_rd   = dd[cache_a[31-TW:2]];
  end

  // Array write port: bench clear/preload, otherwise the DUT write strobe.
  always @(posedge clk) begin
    if (clr_all) begin
      for (int i = 0; i < NL; i++) lv[i] <= 1'b0;
    end else if (pre_en) begin
      lv[pre_a[31-TW:2+LB]] <= 1'b1;
      lt[pre_a[31-TW:2+LB]] <= pre_a[31:32-TW];
      dd[pre_a[31-TW:2]]    <= memval(pre_a);
    end else if (cache_we) begin
      lv[cache_a[31-TW:2+LB]] <= cache_wvalid;
      lt[cache_a[31-TW:2+LB]] <= cache_wtag;
      dd[cache_a[31-TW:2]]    <= cache_wd;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One fetch from issue until instr_valid, checking every cycle on the way.
  task automatic fetch(input logic [31:0] a, input int wmin, input int wmax, input bit wiggle);
    logic [31:0] base;
    bit          exp_hit;
    int          w;
    int          waits;
    int          stalls;
    base    = a & ~LMASK;
    exp_hit = resident.exists(slot(a)) && (resident[slot(a)] == base);
    waits   = 0;
    stalls  = 0;
    pc      = a;
    req     = 1'b1;
    mem_ack = 1'b0;
    @(negedge clk);
    n_chk++;
    if (instr_valid !== exp_hit || stall !== !exp_hit || mem_req !== 1'b0 || cache_we !== 1'b0) begin
      n_fail++;
      $display("FAIL lookup pc=%h: valid=%b stall=%b mem_req=%b we=%b, expected valid=%b stall=%b mem_req=0 we=0",
               a, instr_valid, stall, mem_req, cache_we, exp_hit, !exp_hit);
    end
    if (exp_hit) begin
      exp_hits++;
      n_chk++;
      if (instr !== memval(a)) begin
        n_fail++;
        $display("FAIL hit_data pc=%h: got %h, expected %h", a, instr, memval(a));
      end
      @(posedge clk); #1;
      return;
    end
    exp_misses++;
    if (stall === 1'b1) stalls++;
    @(posedge clk); #1;
    for (int k = 0; k < LW; k++) begin
      w = $urandom_range(wmax, wmin);
      waits += w;
      for (int c = 0; c <= w; c++) begin
        if (wiggle) begin
          pc  = $urandom;
          req = 1'($urandom_range(1, 0));
        end
        mem_ack   = (c == w);
        mem_rdata = (c == w) ? memval(base + 32'(4 * k)) : $urandom;
        @(negedge clk);
        if (stall === 1'b1) stalls++;
        n_chk++;
        if (mem_req !== 1'b1 || stall !== 1'b1 || instr_valid !== 1'b0 ||
            mem_addr !== base + 32'(4 * k) || cache_a !== base + 32'(4 * k) ||
            cache_we !== mem_ack ||
            (mem_ack && (cache_wvalid !== (k == LW - 1) || cache_wtag !== base[31:32-TW]))) begin
          n_fail++;
          $display("FAIL refill pc=%h word %0d: mem_req=%b stall=%b valid=%b mem_addr=%h cache_a=%h we=%b wvalid=%b wtag=%h, expected mem_req=1 stall=1 valid=0 addr=%h we=%b wvalid=%b wtag=%h",
                   a, k, mem_req, stall, instr_valid, mem_addr, cache_a, cache_we, cache_wvalid,
                   cache_wtag, base + 32'(4 * k), mem_ack, (k == LW - 1), base[31:32-TW]);
        end
        @(posedge clk); #1;
      end
    end
    mem_ack = 1'b0;
    pc      = a;
    req     = 1'b1;
    resident[slot(a)] = base;
    @(negedge clk);
    if (stall === 1'b1) stalls++;
    n_chk++;
    if (stall !== 1'b1 || instr_valid !== 1'b0 || mem_req !== 1'b0 || cache_we !== 1'b0) begin
      n_fail++;
      $display("FAIL resume pc=%h: stall=%b valid=%b mem_req=%b we=%b, expected stall=1 valid=0 mem_req=0 we=0",
               a, stall, instr_valid, mem_req, cache_we);
    end
    @(posedge clk); #1;
    @(negedge clk);
    exp_hits++;
    n_chk++;
    if (instr_valid !== 1'b1 || stall !== 1'b0 || instr !== memval(a)) begin
      n_fail++;
      $display("FAIL after_refill pc=%h: valid=%b stall=%b instr=%h, expected valid=1 stall=0 instr=%h",
               a, instr_valid, stall, instr, memval(a));
    end
    n_chk++;
    if (stalls != LW + waits + 2) begin
      n_fail++;
      $display("FAIL penalty pc=%h: stall cycles %0d, expected %0d", a, stalls, LW + waits + 2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = 1'b0;
    pc      = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    clr_all = 1'b1;
    @(posedge clk); #1;
    clr_all = 1'b0;
    for (int k = 0; k < LW; k++) begin
      pre_en = 1'b1;
      pre_a  = 32'h100 + 32'(4 * k);
      @(posedge clk); #1;
    end
    pre_en = 1'b0;
    resident[slot(32'h100)] = 32'h100;
    pc  = 32'h100;
    req = 1'b1;
    @(negedge clk);
    n_chk++;
    if (instr_valid !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0 || cache_we !== 1'b0 ||
        instr !== memval(32'h100)) begin
      n_fail++;
      $display("FAIL reset_hit: valid=%b stall=%b mem_req=%b we=%b instr=%h, expected 1 0 0 0 %h",
               instr_valid, stall, mem_req, cache_we, instr, memval(32'h100));
    end
    n_chk++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counters: hit=%0d miss=%0d, expected 0 0", hit_count, miss_count);
    end
    req = 1'b0;
    @(posedge clk); #1;
    reset_n    = 1'b1;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic test_idle();
    req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pc        = $urandom;
      mem_ack   = 1'($urandom_range(1, 0));
      mem_rdata = $urandom;
      @(negedge clk);
      n_chk++;
      if (instr_valid !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0 || cache_we !== 1'b0) begin
        n_fail++;
        $display("FAIL idle cycle %0d: valid=%b stall=%b mem_req=%b we=%b, expected all 0",
                 i, instr_valid, stall, mem_req, cache_we);
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_miss_basic();
    fetch(32'h1008, 0, 0, 1'b0);
  endtask

  task automatic test_miss_waits();
    fetch(32'h2004, 3, 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) fetch(32'h1000 + 32'(4 * (i % LW)) + 32'(i % 4), 0, 0, 1'b0);
    fetch(32'h2000, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 150; i++) begin
      a = 32'h0000_8000 + ($urandom_range(1, 0) != 0 ? 32'h0004_0000 : 32'h0)
          + 32'(4 * $urandom_range(31, 0)) + 32'($urandom_range(3, 0));
      fetch(a, 0, 2, 1'($urandom_range(1, 0)));
    end
  endtask

  task automatic test_abort();
    logic [31:0] a;
    logic [31:0] b;
    a = 32'h3008;
    b = 32'h0004_3000;
    fetch(b, 0, 0, 1'b0);
    pc  = a;
    req = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      mem_ack   = 1'b1;
      mem_rdata = memval(32'h3000 + 32'(4 * k));
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h3008) begin
      n_fail++;
      $display("FAIL abort_pre: mem_req=%b mem_addr=%h, expected 1 00003008", mem_req, mem_addr);
    end
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (mem_req !== 1'b0 || cache_we !== 1'b0 || instr_valid !== 1'b0 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reset: mem_req=%b we=%b valid=%b stall=%b, expected 0 0 0 1",
               mem_req, cache_we, instr_valid, stall);
    end
    resident.delete(slot(a));
    req = 1'b0;
    @(posedge clk); #1;
    reset_n    = 1'b1;
    exp_hits   = 0;
    exp_misses = 0;
    fetch(b, 0, 1, 1'b0);
    fetch(a, 0, 1, 1'b0);
  endtask

  task automatic test_stats();
    reset_n = 1'b0;
    req     = 1'b0;
    @(posedge clk); #1;
    reset_n    = 1'b1;
    exp_hits   = 0;
    exp_misses = 0;
    fetch(32'h5000, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) fetch(32'h5000 + 32'(4 * i), 0, 0, 1'b0);
    fetch(32'h6000, 0, 2, 1'b0);
    fetch(32'h0004_5000, 1, 2, 1'b0);
    @(negedge clk);
`ifdef ICACHE_STATS_EN
    n_chk++;
    if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
      n_fail++;
      $display("FAIL stats: hit_count=%0d miss_count=%0d, expected %0d %0d",
               hit_count, miss_count, exp_hits, exp_misses);
    end
`else
    n_chk++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_off: hit_count=%0d miss_count=%0d, expected 0 0", hit_count, miss_count);
    end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_miss_basic();
    test_miss_waits();
    test_back_to_back();
    test_random();
    test_abort();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
